// File: rtl/mips_multicycle_control_if.sv
// Control-unit <-> datapath bundle: opcode and memory handshake in, mux selects and enables out.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       regdst;
  logic       alusrc;
  logic       memtoreg;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output regdst, alusrc, memtoreg, alu_op, reg_write, mem_read, mem_write,
           iord, ir_write, pc_write, pc_write_cond, pc_src, instr_done, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  regdst, alusrc, memtoreg, alu_op, reg_write, mem_read, mem_write,
           iord, ir_write, pc_write, pc_write_cond, pc_src, instr_done, illegal, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing with
// a memory-ready stall in FETCH, MEM_RD and MEM_WR.
module mips_multicycle_control (
  input logic                        clock,
  input logic                        reset,
  mips_multicycle_control_if.master  bus
);

  localparam logic [3:0] S_RESET   = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC_R  = 4'd3;
  localparam logic [3:0] S_WB_R    = 4'd4;
  localparam logic [3:0] S_ADDR    = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_WB_MEM  = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_EXEC_I  = 4'd9;
  localparam logic [3:0] S_WB_I    = 4'd10;
  localparam logic [3:0] S_BRANCH  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;
  localparam logic [3:0] S_ILLEGAL = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_q, state_d;
  logic [5:0] opcode_q, opcode_d;

  // The latched opcode is only consumed after DECODE has loaded it, so it needs no reset.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
    opcode_q <= opcode_d;
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = bus.opcode;
        case (bus.opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_ADDR:   state_d = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (bus.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_I: state_d = S_WB_I;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs from state_q; FETCH and MEM_WR also gate their commit signals on mem_ready.
  always_comb begin
    bus.regdst        = 1'b0;
    bus.alusrc        = 1'b0;
    bus.memtoreg      = 1'b0;
    bus.alu_op        = 2'b00;
    bus.reg_write     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 2'b00;
    bus.instr_done    = 1'b0;
    bus.illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      S_EXEC_R: bus.alu_op = 2'b10;
      S_WB_R: begin
        bus.regdst     = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_ADDR, S_EXEC_I: bus.alusrc = 1'b1;
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_WB_MEM: begin
        bus.memtoreg   = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_WB_I: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
        bus.instr_done    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = 2'b10;
        bus.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        bus.illegal    = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-cycle vector table plus a randomised MEM_RD stall,
// expected output words queued at drive time and compared mid-cycle.
module tb_mips_multicycle_control;

  // {state, regdst, alusrc, memtoreg, alu_op, reg_write, mem_read, mem_write, iord,
  //  ir_write, pc_write, pc_write_cond, pc_src, instr_done, illegal}
  function automatic logic [19:0] ow(input logic [3:0] s, input logic rd, as, mt,
                                     input logic [1:0] ao, input logic rw, mr, mw, io,
                                     iw, pw, pwc, input logic [1:0] ps, input logic dn, il);
    return {s, rd, as, mt, ao, rw, mr, mw, io, iw, pw, pwc, ps, dn, il};
  endfunction

  localparam logic [19:0] RST   = ow(4'd0,  0,0,0,2'b00, 0,0,0,0, 0,0,0, 2'b00, 0,0);
  localparam logic [19:0] FET_W = ow(4'd1,  0,0,0,2'b00, 0,1,0,0, 0,0,0, 2'b00, 0,0);
  localparam logic [19:0] FET_R = ow(4'd1,  0,0,0,2'b00, 0,1,0,0, 1,1,0, 2'b00, 0,0);
  localparam logic [19:0] DEC   = ow(4'd2,  0,0,0,2'b00, 0,0,0,0, 0,0,0, 2'b00, 0,0);
  localparam logic [19:0] EXR   = ow(4'd3,  0,0,0,2'b10, 0,0,0,0, 0,0,0, 2'b00, 0,0);
  localparam logic [19:0] WBR   = ow(4'd4,  1,0,0,2'b00, 1,0,0,0, 0,0,0, 2'b00, 1,0);
  localparam logic [19:0] ADR   = ow(4'd5,  0,1,0,2'b00, 0,0,0,0, 0,0,0, 2'b00, 0,0);
  localparam logic [19:0] MRD   = ow(4'd6,  0,0,0,2'b00, 0,1,0,1, 0,0,0, 2'b00, 0,0);
  localparam logic [19:0] WBM   = ow(4'd7,  0,0,1,2'b00, 1,0,0,0, 0,0,0, 2'b00, 1,0);
  localparam logic [19:0] MWR_W = ow(4'd8,  0,0,0,2'b00, 0,0,1,1, 0,0,0, 2'b00, 0,0);
  localparam logic [19:0] MWR_R = ow(4'd8,  0,0,0,2'b00, 0,0,1,1, 0,0,0, 2'b00, 1,0);
  localparam logic [19:0] EXI   = ow(4'd9,  0,1,0,2'b00, 0,0,0,0, 0,0,0, 2'b00, 0,0);
  localparam logic [19:0] WBI   = ow(4'd10, 0,0,0,2'b00, 1,0,0,0, 0,0,0, 2'b00, 1,0);
  localparam logic [19:0] BR    = ow(4'd11, 0,0,0,2'b01, 0,0,0,0, 0,0,1, 2'b01, 1,0);
  localparam logic [19:0] JMP   = ow(4'd12, 0,0,0,2'b00, 0,0,0,0, 0,1,0, 2'b10, 1,0);
  localparam logic [19:0] ILL   = ow(4'd13, 0,0,0,2'b00, 0,0,0,0, 0,0,0, 2'b00, 1,1);

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [19:0] exp;
  } vec_t;

  typedef struct {
    int          tag;
    logic [19:0] exp;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tag_n = 0;

  function automatic logic [19:0] obs();
    return {bus.state, bus.regdst, bus.alusrc, bus.memtoreg, bus.alu_op, bus.reg_write,
            bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
            bus.pc_write_cond, bus.pc_src, bus.instr_done, bus.illegal};
  endfunction

  function automatic void add(input logic r, input logic [5:0] op, input logic rdy,
                              input logic [19:0] exp);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [19:0] exp, input bit chk);
    sb_t e;
    @(negedge clock);
    reset         = r;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    if (chk) begin
      e.tag = tag_n;
      e.exp = exp;
      sb.push_back(e);
      tag_n++;
    end
    @(posedge clock);
  endtask

  // Mid-cycle monitor: pops the expectation pushed at this cycle's drive.
  always @(negedge clock) begin
    sb_t e;
    logic [19:0] got;
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = obs();
      n_cmp++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL step%0d outputs: got %05h want %05h (state got %0d want %0d)",
                 e.tag, got, e.exp, got[19:16], e.exp[19:16]);
      end
      if (bus.state != 4'd1) begin
        n_cmp++;
        if ((32'(bus.reg_write) + 32'(bus.mem_write) + 32'(bus.pc_write)) > 1) begin
          n_bad++;
          $display("FAIL step%0d write_excl: got rw=%b mw=%b pw=%b want at most one",
                   e.tag, bus.reg_write, bus.mem_write, bus.pc_write);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int guard;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b0;

    // reset held, then released
    add(1, R, 0, RST); add(1, R, 1, RST); add(1, R, 0, RST); add(0, R, 0, RST);
    // R-type
    add(0, BAD, 1, FET_R); add(0, R, 0, DEC); add(0, LW, 1, EXR); add(0, R, 0, WBR);
    // lw, two MEM_RD stall cycles, opcode disturbed after DECODE
    add(0, R, 1, FET_R); add(0, LW, 1, DEC); add(0, SW, 1, ADR);
    add(0, SW, 0, MRD); add(0, R, 0, MRD); add(0, R, 1, MRD); add(0, R, 1, WBM);
    // sw, beq, j each with one FETCH stall
    add(0, R, 0, FET_W); add(0, R, 1, FET_R); add(0, SW, 0, DEC); add(0, LW, 0, ADR);
    add(0, R, 1, MWR_R);
    add(0, R, 0, FET_W); add(0, R, 1, FET_R); add(0, BEQ, 0, DEC); add(0, R, 1, BR);
    add(0, R, 0, FET_W); add(0, R, 1, FET_R); add(0, J, 0, DEC); add(0, R, 0, JMP);
    // illegal opcode
    add(0, R, 1, FET_R); add(0, BAD, 1, DEC); add(0, R, 1, ILL);
    // addi with opcode changed after DECODE
    add(0, R, 1, FET_R); add(0, ADDI, 1, DEC); add(0, R, 0, EXI); add(0, J, 0, WBI);
    // reset during MEM_WR stall
    add(0, R, 1, FET_R); add(0, SW, 1, DEC); add(0, R, 0, ADR);
    add(0, R, 0, MWR_W); add(1, R, 0, MWR_W); add(0, R, 1, RST); add(0, R, 1, FET_R);
    add(0, R, 1, DEC); add(0, R, 0, EXR); add(0, R, 0, WBR);

    step(1, R, 0, RST, 0);
    foreach (tbl[i]) step(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].exp, 1);

    // lw with a random-length MEM_RD stall: outputs must hold until mem_ready
    n = $urandom_range(3, 6);
    step(0, R, 1, FET_R, 1);
    step(0, LW, 0, DEC, 1);
    step(0, R, 0, ADR, 1);
    for (int k = 0; k < n; k++) step(0, 6'($urandom), 0, MRD, 1);
    step(0, R, 1, MRD, 1);
    step(0, R, 0, WBM, 1);
    // j with a three-cycle FETCH stall
    step(0, R, 0, FET_W, 1);
    step(0, R, 0, FET_W, 1);
    step(0, R, 0, FET_W, 1);
    step(0, R, 1, FET_R, 1);
    step(0, J, 1, DEC, 1);
    step(0, R, 1, JMP, 1);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It produces the select lines consumed by the datapath multiplexors: register destination, ALU operand-B source and write-back source. It also produces the register-file, memory and PC enables, and stalls on a memory-ready handshake. The datapath's muxes, ALU, register file and memory are its only consumers.

## Interface

Parameters: none (opcode encodings fixed below).

- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26] from the external instruction register; valid from DECODE onward
- mem_ready  input  1  memory completes the current read/write this cycle
- regdst  output  1  0 = rt, 1 = rd as write register
- alusrc  output  1  0 = register rt, 1 = sign-extended immediate as ALU operand B
- memtoreg  output  1  0 = ALU result, 1 = memory data as write-back value
- alu_op  output  2  00 add, 01 subtract, 10 decode funct
- reg_write  output  1  register-file write enable
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- iord  output  1  0 = PC, 1 = ALU result as memory address
- ir_write  output  1  instruction register load
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- pc_src  output  2  00 PC+4, 01 branch target, 10 jump target
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction, including illegal
- illegal  output  1  one-cycle pulse for an unsupported opcode
- state  output  4  current state (debug)

## Operation

Opcodes:
- R-type 000000
- lw 100011
- sw 101011
- beq 000100
- addi 001000
- j 000010
- anything else is illegal

Opcode handling:
- Opcode is latched into an internal register in DECODE.
- ADDR uses the latched value, not the live input.

States are Moore-decoded from the state register unless marked (M). Every output not listed is 0.
- RESET (0): all outputs 0. -> FETCH.
- FETCH (1): mem_read=1, iord=0.
  - (M) ir_write=pc_write=mem_ready, pc_src=00.
  - mem_ready -> DECODE, else stay.
- DECODE (2): latch opcode.
  - R-type -> EXEC_R
  - lw/sw -> ADDR
  - beq -> BRANCH
  - addi -> EXEC_I
  - j -> JUMP
  - else -> ILLEGAL
- EXEC_R (3): alusrc=0, alu_op=10. -> WB_R.
- WB_R (4): regdst=1, memtoreg=0, reg_write=1, instr_done=1. -> FETCH.
- ADDR (5): alusrc=1, alu_op=00. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD (6): mem_read=1, iord=1. mem_ready -> WB_MEM, else stay.
- WB_MEM (7): regdst=0, memtoreg=1, reg_write=1, instr_done=1. -> FETCH.
- MEM_WR (8): mem_write=1, iord=1.
  - (M) instr_done=mem_ready.
  - mem_ready -> FETCH, else stay.
- EXEC_I (9): alusrc=1, alu_op=00. -> WB_I.
- WB_I (10): regdst=0, memtoreg=0, reg_write=1, instr_done=1. -> FETCH.
- BRANCH (11): alusrc=0, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1. -> FETCH.
- JUMP (12): pc_write=1, pc_src=10, instr_done=1. -> FETCH.
- ILLEGAL (13): illegal=1, instr_done=1, no write enables. -> FETCH.
- Encodings 14–15 are unreachable. If entered, decode as RESET and go to FETCH.

## Timing

- Reset sampled high at an edge -> state=RESET after that edge, in any state, including mid-stall in MEM_RD/MEM_WR. The pending memory request drops the same cycle.
- Reset held: remains in RESET, all outputs 0.
- First FETCH is the cycle after reset is sampled low.
- Cycle counts with mem_ready=1 in every FETCH and memory state:
  - R-type 4, addi 4
  - lw 5, sw 4
  - beq 3, j 3
  - illegal 3
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
  - Outputs are held constant throughout the stall.
  - ir_write/pc_write/instr_done stay 0 until mem_ready=1.
- Only one of reg_write, mem_write, pc_write may be asserted in any cycle, except FETCH (pc_write with ir_write).
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Opcode changes after DECODE do not affect the sequence.

## Test plan

- Reset 3 cycles, then release -> all outputs 0 and state=0 while held. Next cycle state=1, mem_read=1, iord=0.
- R-type, mem_ready=1 -> states 1,2,3,4. Cycle 3: alusrc=0, alu_op=10. Cycle 4: regdst=1, reg_write=1, instr_done=1. Then back to 1.
- lw, mem_ready low 2 cycles in MEM_RD -> states 1,2,5,6,6,6,7 (7 cycles). iord=1 held during 6. No reg_write until 7, where memtoreg=1, regdst=0.
- sw, beq, j back-to-back, with FETCH mem_ready low 1 cycle each:
  - sw -> 5 cycles, mem_write only in state 8.
  - beq -> 4 cycles, pc_write_cond=1, pc_src=01, alu_op=01.
  - j -> 4 cycles, pc_write=1, pc_src=10.
- opcode 111111 -> states 1,2,13,1. illegal=instr_done=1 for exactly one cycle, all write enables 0.
- Reset asserted during MEM_WR stall -> next cycle state=0, mem_write=0, no instr_done. Opcode change after DECODE of addi -> still WB_I.
